change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream end of the vending controller's output interface. Consumes the controller's single-cycle request pulses `dispense`, `one_balance` and `two_balance`, and queues them as pending counts. Drives the item motor and the two coin-hopper ejectors one unit at a time, each closed by an exit-sensor acknowledge. Detects a jammed mechanism by timeout and reports a sticky fault to the top level.

Parameters:
CNT_W, 3, width of each pending-request counter (max pending = 2^CNT_W-1)
TIMEOUT_CYC, 8, cycles a drive may stay high without its sensor before timeout (must be >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
dispense  input  1  1-cycle pulse: release one item
one_balance  input  1  1-cycle pulse: pay out one Rs1 coin
two_balance  input  1  1-cycle pulse: pay out one Rs2 coin
item_sensed  input  1  item-drop sensor, 1-cycle pulse per item
one_sensed  input  1  Rs1 exit sensor, 1-cycle pulse per coin
two_sensed  input  1  Rs2 exit sensor, 1-cycle pulse per coin
item_drive  output  1  item motor enable (registered)
one_drive  output  1  Rs1 ejector enable (registered)
two_drive  output  1  Rs2 ejector enable (registered)
busy  output  1  state!=IDLE or any pending count nonzero
fault  output  1  sticky jam indication
overflow  output  1  sticky: a request arrived while its counter was at max

Behaviour:
- Reset (sampled at an edge): all drives=0, fault=0, overflow=0, busy=0, all counters=0, state=IDLE, timer=0. Reset mid-payout aborts it immediately; the drive is low after that edge.
- Pending counters (item, two, one): increment on their request pulse.
  - Saturate at max; a request at max is dropped and sets overflow.
  - Decrement when the matching sensor pulse is accepted.
  - Increment and decrement on the same edge leave the count unchanged.
- FSM states: IDLE, ITEM, TWO, ONE, GAP, FAULT.
  - IDLE: select by priority item > two > one among nonzero counters, then enter that serve state. A request sampled at edge k gives count!=0 after k, state and drive high after k+1.
  - Serve state: exactly its drive=1; timer increments each cycle.
  - Matching sensor=1 at edge m: counter decrements, drive=0 and state=GAP after m, timer clears.
  - GAP: lasts 1 cycle with all drives low, then IDLE.
  - Timer reaching TIMEOUT_CYC without the sensor: enter FAULT. Drives=0, fault=1. Counters keep accepting requests (saturating). Only reset exits FAULT.
  - A sensor pulse that does not match the current serve state (including any sensor in IDLE, GAP or FAULT) is ignored.
  - A request for a higher-priority type that arrives mid-serve does not preempt; it is chosen at the next IDLE.
- At most one drive high in any cycle.

Optional Feature:
Macro CHANGE_DISPENSER_RETRY_EN.
- Defined: the first timeout of a unit goes to GAP, then re-serves the same type with the timer cleared. A second consecutive timeout on that unit enters FAULT. The retry flag clears on an accepted sensor pulse.
- Undefined: the first timeout enters FAULT directly.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (IDLE, ITEM, TWO, ONE, GAP, FAULT)
  - coin denomination constants (RS1=1, RS2=2, RS5=5)
  - default CNT_W and TIMEOUT_CYC localparams
- One natural sub-module: pay_counter, a saturating up/down counter with an overflow output. Instantiated three times.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, busy=0.
- Single one_balance pulse at edge k; one_sensed pulsed 3 cycles after one_drive rises -> one_drive high after k+1, low after the sensor edge; busy drops after the GAP cycle.
- dispense, two_balance and one_balance pulsed in the same cycle; each sensor returned after 2 cycles -> drives rise in the order item, two, one, each separated by a 1-cycle all-low GAP; pending counts end at 0.
- 8 one_balance pulses with CNT_W=3 and no sensor -> count saturates at 7 and overflow=1.
- one_balance with one_sensed never asserted -> fault=1 and one_drive=0 exactly TIMEOUT_CYC cycles after the drive rises.
  - With RETRY_EN: a second drive pulse first, then fault.
- Reset asserted while two_drive=1 -> two_drive=0 and fault=0 after that edge; a stray two_sensed afterwards is ignored.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, coin denominations and default sizing for the vending output path.
package vm_pkg;
   typedef enum logic [2:0] {IDLE, ITEM, TWO, ONE, GAP, FAULT} state_t;
   localparam int RS1 = 1;
   localparam int RS2 = 2;
   localparam int RS5 = 5;
   localparam int CNT_W_DEF = 3;
   localparam int TIMEOUT_CYC_DEF = 8;
endpackage

// File: rtl/pay_counter.sv
// pay_counter: saturating up/down pending-request counter with a sticky overflow flag.
module pay_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         overflow
);
   logic [W-1:0] r_count;
   logic         r_ovf;
   logic         w_max;
   assign w_max = &r_count;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (inc && !dec && !w_max) r_count <= r_count + W'(1);
         else if (dec && !inc && |r_count) r_count <= r_count - W'(1);
         if (inc && !dec && w_max) r_ovf <= 1'b1;
      end
   end
   assign count    = r_count;
   assign overflow = r_ovf;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues item/coin requests and drives one mechanism at a time with jam timeout.
// CHANGE_DISPENSER_RETRY_EN: one retry after a first timeout before declaring a fault.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic dispense,
   input  logic one_balance,
   input  logic two_balance,
   input  logic item_sensed,
   input  logic one_sensed,
   input  logic two_sensed,
   output logic item_drive,
   output logic one_drive,
   output logic two_drive,
   output logic busy,
   output logic fault,
   output logic overflow
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   state_t         r_state, w_next, w_to_state, w_gap_next;
   logic [TW-1:0]  r_timer, w_timer;
   logic [CNT_W-1:0] w_item_cnt, w_two_cnt, w_one_cnt;
   logic           w_item_ov, w_two_ov, w_one_ov;
   logic           w_item_dec, w_two_dec, w_one_dec, w_sensed, w_serving, w_timeout;
   assign w_item_dec = (r_state == ITEM) && item_sensed;
   assign w_two_dec  = (r_state == TWO) && two_sensed;
   assign w_one_dec  = (r_state == ONE) && one_sensed;
   assign w_sensed   = w_item_dec || w_two_dec || w_one_dec;
   assign w_serving  = (r_state == ITEM) || (r_state == TWO) || (r_state == ONE);
   assign w_timeout  = w_serving && !w_sensed && (r_timer == T_LAST);
   pay_counter #(.W(CNT_W)) u_item (.clk(clk), .reset(reset), .inc(dispense), .dec(w_item_dec),
                                    .count(w_item_cnt), .overflow(w_item_ov));
   pay_counter #(.W(CNT_W)) u_two (.clk(clk), .reset(reset), .inc(two_balance), .dec(w_two_dec),
                                   .count(w_two_cnt), .overflow(w_two_ov));
   pay_counter #(.W(CNT_W)) u_one (.clk(clk), .reset(reset), .inc(one_balance), .dec(w_one_dec),
                                   .count(w_one_cnt), .overflow(w_one_ov));
`ifdef CHANGE_DISPENSER_RETRY_EN
   logic   r_retry;
   state_t r_last;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retry <= 1'b0;
         r_last  <= IDLE;
      end else if (w_sensed) begin
         r_retry <= 1'b0;
      end else if (w_timeout && !r_retry) begin
         r_retry <= 1'b1;
         r_last  <= r_state;
      end
   end
   // A retried unit goes straight back to its own type, bypassing priority selection.
   assign w_to_state = r_retry ? FAULT : GAP;
   assign w_gap_next = r_retry ? r_last : IDLE;
`else
   assign w_to_state = FAULT;
   assign w_gap_next = IDLE;
`endif
   always_comb begin
      w_next  = r_state;
      w_timer = '0;
      case (r_state)
         IDLE: w_next = |w_item_cnt ? ITEM : |w_two_cnt ? TWO : |w_one_cnt ? ONE : IDLE;
         ITEM, TWO, ONE: begin
            w_next  = w_sensed ? GAP : w_timeout ? w_to_state : r_state;
            w_timer = (w_sensed || w_timeout) ? '0 : r_timer + TW'(1);
         end
         GAP: w_next = w_gap_next;
         default: w_next = FAULT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_next;
         r_timer <= w_timer;
      end
   end
   assign item_drive = (r_state == ITEM);
   assign two_drive  = (r_state == TWO);
   assign one_drive  = (r_state == ONE);
   assign fault      = (r_state == FAULT);
   assign busy       = (r_state != IDLE) || |w_item_cnt || |w_two_cnt || |w_one_cnt;
   assign overflow   = w_item_ov || w_two_ov || w_one_ov;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: vector table for normal payouts plus directed saturation, timeout and reset cases.
module tb_change_dispenser;
   localparam int T = 8;
   localparam logic [6:0] RST = 7'b1000000, DSP = 7'b0100000, B1 = 7'b0010000, B2 = 7'b0001000;
   localparam logic [6:0] IS = 7'b0000100, OS = 7'b0000010, TS = 7'b0000001, NO = 7'b0000000;
   localparam logic [5:0] D_IT = 6'b100000, D_1 = 6'b010000, D_2 = 6'b001000;
   localparam logic [5:0] BSY = 6'b000100, FLT = 6'b000010, OVF = 6'b000001, Z = 6'b000000;
   logic clk = 1'b0;
   logic reset = 1'b1, dispense = 1'b0, one_balance = 1'b0, two_balance = 1'b0;
   logic item_sensed = 1'b0, one_sensed = 1'b0, two_sensed = 1'b0;
   logic item_drive, one_drive, two_drive, busy, fault, overflow;
   int checks = 0;
   int errors = 0;
   typedef struct {
      string      name;
      logic [6:0] in;
      logic [5:0] exp;
   } vec_t;
   vec_t vecs[$];
   change_dispenser #(.CNT_W(3), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset), .dispense(dispense), .one_balance(one_balance),
      .two_balance(two_balance), .item_sensed(item_sensed), .one_sensed(one_sensed),
      .two_sensed(two_sensed), .item_drive(item_drive), .one_drive(one_drive),
      .two_drive(two_drive), .busy(busy), .fault(fault), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic step(input logic [6:0] in);
      {reset, dispense, one_balance, two_balance, item_sensed, one_sensed, two_sensed} = in;
      @(posedge clk);
      #1;
      {reset, dispense, one_balance, two_balance, item_sensed, one_sensed, two_sensed} = NO;
   endtask
   task automatic chk(input string name, input logic [5:0] exp);
      logic [5:0] act;
      act = {item_drive, one_drive, two_drive, busy, fault, overflow};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got item/one/two/busy/fault/ovf=%b want %b", name, act, exp);
      end
   endtask
   task automatic run(input string name, input logic [6:0] in, input logic [5:0] exp);
      step(in);
      chk(name, exp);
   endtask
   initial begin
      vecs.push_back('{"rst0", RST, Z});
      vecs.push_back('{"rst1", RST, Z});
      vecs.push_back('{"idle", NO, Z});
      vecs.push_back('{"one_req", B1, BSY});
      vecs.push_back('{"one_drv_idle_sensor", OS, D_1 | BSY});
      vecs.push_back('{"one_hold1", NO, D_1 | BSY});
      vecs.push_back('{"one_hold2", NO, D_1 | BSY});
      vecs.push_back('{"one_sense", OS, BSY});
      vecs.push_back('{"one_gap_end", NO, Z});
      vecs.push_back('{"all_req", DSP | B1 | B2, BSY});
      vecs.push_back('{"item_drv", NO, D_IT | BSY});
      vecs.push_back('{"item_wrong_sensor", OS | TS, D_IT | BSY});
      vecs.push_back('{"item_sense", IS, BSY});
      vecs.push_back('{"idle_sel_two", IS, BSY});
      vecs.push_back('{"two_drv", NO, D_2 | BSY});
      vecs.push_back('{"two_hold", NO, D_2 | BSY});
      vecs.push_back('{"two_sense", TS, BSY});
      vecs.push_back('{"idle_sel_one_gap_sensor", OS, BSY});
      vecs.push_back('{"one_drv2", NO, D_1 | BSY});
      vecs.push_back('{"one_hold3", NO, D_1 | BSY});
      vecs.push_back('{"one_sense2", OS, BSY});
      vecs.push_back('{"all_done", NO, Z});
      foreach (vecs[i]) run(vecs[i].name, vecs[i].in, vecs[i].exp);
      // Saturation: the drive starts while requests pile up, but no timeout yet.
      run("sat_rst", RST, Z);
      for (int i = 0; i < 7; i++) step(B1);
      chk("sat_7_no_ovf", D_1 | BSY);
      run("sat_8_ovf", B1, D_1 | BSY | OVF);
      // Timeout with the sensor never returning.
      run("to_rst", RST, Z);
      run("to_req", B1, BSY);
      run("to_rise", NO, D_1 | BSY);
      for (int j = 1; j < T; j++) run("to_hold", NO, D_1 | BSY);
`ifdef CHANGE_DISPENSER_RETRY_EN
      run("retry_gap", NO, BSY);
      run("retry_rise", NO, D_1 | BSY);
      for (int j = 1; j < T; j++) run("retry_hold", NO, D_1 | BSY);
`endif
      run("to_fault", NO, FLT | BSY);
      run("fault_stray_sensor", OS, FLT | BSY);
      run("fault_sticky_req", B2, FLT | BSY);
      // Reset in the middle of a Rs2 payout.
      run("mid_rst", RST, Z);
      run("mid_req", B2, BSY);
      run("mid_rise", NO, D_2 | BSY);
      run("mid_hold", NO, D_2 | BSY);
      run("mid_reset_abort", RST, Z);
      run("mid_stray_sensor", TS, Z);
      run("mid_quiet", NO, Z);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
